// File: rtl/ysyx22041405_wb_arbiter.sv
// Writeback arbiter: round-robin EXU/LSU arbitration onto the single regfile write port,
// plus a per-register busy scoreboard that holds back issue on RAW/WAW hazards.
module ysyx22041405_wb_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [4:0]       exu_rd,
  input  logic [WIDTH-1:0] exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [4:0]       iss_rs1,
  input  logic [4:0]       iss_rs2,
  input  logic [4:0]       iss_rd,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             wb_err
);

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e             rr_last;
  src_e             rr_last_next;
  logic             grant_exu;
  logic             grant_lsu;
  logic             grant_any;
  logic [4:0]       grant_rd;
  logic [WIDTH-1:0] grant_data;
  logic             grant_writes;
  logic             issue_fire;
  logic             err_set;
  logic [31:0]      busy;
  logic [31:0]      busy_next;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_exu    = 1'b0;
    grant_lsu    = 1'b0;
    rr_last_next = rr_last;
    if (exu_valid && lsu_valid) begin
      if (rr_last == SRC_LSU) grant_exu = 1'b1;
      else                    grant_lsu = 1'b1;
    end else if (exu_valid) begin
      grant_exu = 1'b1;
    end else if (lsu_valid) begin
      grant_lsu = 1'b1;
    end
    if (grant_exu)      rr_last_next = SRC_EXU;
    else if (grant_lsu) rr_last_next = SRC_LSU;
  end

  assign exu_ready    = grant_exu;
  assign lsu_ready    = grant_lsu;
  assign grant_any    = grant_exu | grant_lsu;
  assign grant_rd     = grant_lsu ? lsu_rd   : exu_rd;
  assign grant_data   = grant_lsu ? lsu_data : exu_data;
  assign grant_writes = grant_any && (grant_rd != 5'd0);
  assign err_set      = grant_writes && !busy[grant_rd];

  assign iss_ready  = ~(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
  assign issue_fire = iss_valid && iss_ready && (iss_rd != 5'd0);

  // Clear for the register being written this cycle, set for the issuing destination.
  always_comb begin
    busy_next = busy;
    if (rf_we)      busy_next[rf_waddr] = 1'b0;
    if (issue_fire) busy_next[iss_rd]   = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= SRC_LSU;
      busy     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      rr_last <= rr_last_next;
      busy    <= busy_next;
      rf_we   <= grant_writes;
      if (grant_writes) begin
        rf_waddr <= grant_rd;
        rf_wdata <= grant_data;
      end
      if (err_set) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx22041405_wb_arbiter.sv
// Bench for ysyx22041405_wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared against a behavioural model of the arbiter and scoreboard.
module tb_ysyx22041405_wb_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             exu_valid, exu_ready;
  logic [4:0]       exu_rd;
  logic [WIDTH-1:0] exu_data;
  logic             lsu_valid, lsu_ready;
  logic [4:0]       lsu_rd;
  logic [WIDTH-1:0] lsu_data;
  logic             iss_valid, iss_ready;
  logic [4:0]       iss_rs1, iss_rs2, iss_rd;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic             wb_err;

  int vectors     = 0;
  int miscompares = 0;

  ysyx22041405_wb_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Reference model state: set of busy registers, who won last, pending regfile write, error flag.
  bit [31:0] m_busy;
  bit        m_last_lsu;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_err;

  function automatic bit f_grant_exu();
    return exu_valid && (!lsu_valid || m_last_lsu);
  endfunction

  function automatic bit f_grant_lsu();
    return lsu_valid && (!exu_valid || !m_last_lsu);
  endfunction

  function automatic bit f_iss_ready();
    return !(m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
  endfunction

  always @(posedge clk) begin : model
    bit        ge, gl, ir;
    bit [4:0]  rd;
    bit [31:0] d, nb;
    if (rst) begin
      m_busy = '0; m_last_lsu = 1'b1; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    end else begin
      ge = f_grant_exu();
      gl = f_grant_lsu();
      ir = f_iss_ready();
      rd = ge ? exu_rd : lsu_rd;
      d  = ge ? exu_data : lsu_data;
      if ((ge || gl) && rd != 0 && !m_busy[rd]) m_err = 1'b1;
      nb = m_busy;
      if (m_we) nb[m_waddr] = 1'b0;
      if (iss_valid && ir && iss_rd != 0) nb[iss_rd] = 1'b1;
      m_busy = nb;
      if (ge)      m_last_lsu = 1'b0;
      else if (gl) m_last_lsu = 1'b1;
      m_we = (ge || gl) && rd != 0;
      if (m_we) begin
        m_waddr = rd;
        m_wdata = d;
      end
    end
  end

  task automatic idle_inputs();
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    iss_rs1 = 5'd1; iss_rs2 = 5'd2; iss_rd = 5'd3;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rf_we got %b want 0", rf_we); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb_err got %b want 0", wb_err); end
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_iss_ready got %b want 1", iss_ready); end
    vectors++; if (exu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_exu_ready got %b want 0", exu_ready); end
  endtask

  task automatic test_issue_writeback();
    @(negedge clk);
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 5'd5;
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL iw_issue got %b want 1", iss_ready); end
    @(negedge clk);
    iss_rs1 = 5'd5; iss_rd = 5'd0;
    exu_valid = 1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    #1;
    vectors++; if (exu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL iw_exu_ready got %b want 1", exu_ready); end
    vectors++; if (iss_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL iw_stall_n got %b want 0", iss_ready); end
    @(negedge clk);
    exu_valid = 0;
    #1;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL iw_rf_we got %b want 1", rf_we); end
    vectors++; if (rf_waddr !== 5'd5) begin miscompares++; $display("[TB] FAIL iw_waddr got %0d want 5", rf_waddr); end
    vectors++; if (rf_wdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL iw_wdata got %h want deadbeef", rf_wdata); end
    vectors++; if (iss_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL iw_stall_n1 got %b want 0", iss_ready); end
    @(negedge clk);
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL iw_ready_n2 got %b want 1", iss_ready); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL iw_wb_err got %b want 0", wb_err); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int er[2]      = '{10, 12};
    int lr[2]      = '{11, 13};
    int order[4]   = '{10, 11, 12, 13};
    bit pat_lsu[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int ei = 0;
    int li = 0;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 5'(10 + i);
      #1;
      vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_issue%0d got %b want 1", i, iss_ready); end
      @(negedge clk);
    end
    iss_valid = 0;
    for (int c = 0; c < 5; c++) begin
      exu_valid = (ei < 2); exu_rd = 5'(er[ei < 2 ? ei : 0]); exu_data = 32'hE000_0000 + 32'(ei);
      lsu_valid = (li < 2); lsu_rd = 5'(lr[li < 2 ? li : 0]); lsu_data = 32'h1000_0000 + 32'(li);
      #1;
      if (c < 4) begin
        vectors++; if (exu_ready !== !pat_lsu[c]) begin miscompares++; $display("[TB] FAIL b2b_exu_ready%0d got %b want %b", c, exu_ready, !pat_lsu[c]); end
        vectors++; if (lsu_ready !== pat_lsu[c]) begin miscompares++; $display("[TB] FAIL b2b_lsu_ready%0d got %b want %b", c, lsu_ready, pat_lsu[c]); end
        if (pat_lsu[c]) li++; else ei++;
      end
      if (c > 0) begin
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rf_we%0d got %b want 1", c, rf_we); end
        vectors++; if (rf_waddr !== 5'(order[c-1])) begin miscompares++; $display("[TB] FAIL b2b_waddr%0d got %0d want %0d", c, rf_waddr, order[c-1]); end
      end
      @(negedge clk);
    end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_wb_err got %b want 0", wb_err); end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    #1;
    vectors++; if (lsu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd0_lsu_ready got %b want 1", lsu_ready); end
    @(negedge clk);
    lsu_valid = 0;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd0_rf_we got %b want 0", rf_we); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rd0_wb_err got %b want 0", wb_err); end
    @(negedge clk);
  endtask

  task automatic test_wb_error();
    exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h0000_0777;
    #1;
    vectors++; if (exu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL err_exu_ready got %b want 1", exu_ready); end
    @(negedge clk);
    exu_valid = 0;
    #1;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL err_rf_we got %b want 1", rf_we); end
    vectors++; if (rf_waddr !== 5'd7) begin miscompares++; $display("[TB] FAIL err_waddr got %0d want 7", rf_waddr); end
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_set got %b want 1", wb_err); end
    repeat (3) @(negedge clk);
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky got %b want 1", wb_err); end
  endtask

  task automatic test_reset_in_grant();
    pulse_reset();
    iss_valid = 1; iss_rd = 5'd9;
    #1;
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rg_issue got %b want 1", iss_ready); end
    @(negedge clk);
    iss_valid = 0; iss_rd = 0;
    exu_valid = 1; exu_rd = 5'd9; exu_data = 32'h9999_9999;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exu_valid = 0;
    iss_rs1 = 5'd9;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rg_rf_we got %b want 0", rf_we); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rg_wb_err got %b want 0", wb_err); end
    vectors++; if (iss_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rg_busy9 got %b want 1", iss_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Mostly target registers the model believes busy, occasionally anything in 0..7.
  function automatic bit [4:0] pick_rd();
    bit [4:0] cand[$];
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 7));
    for (int r = 1; r < 8; r++) if (m_busy[r]) cand.push_back(5'(r));
    if (cand.size() == 0) return 5'd0;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic test_random(input int cycles);
    bit e_pend = 0;
    bit l_pend = 0;
    bit ge = 0;
    bit gl = 0;
    pulse_reset();
    for (int c = 0; c < cycles; c++) begin
      vectors++; if (rf_we !== m_we) begin miscompares++; $display("[TB] FAIL rnd_rf_we c%0d got %b want %b", c, rf_we, m_we); end
      vectors++; if (wb_err !== m_err) begin miscompares++; $display("[TB] FAIL rnd_wb_err c%0d got %b want %b", c, wb_err, m_err); end
      if (m_we) begin
        vectors++; if (rf_waddr !== m_waddr) begin miscompares++; $display("[TB] FAIL rnd_waddr c%0d got %0d want %0d", c, rf_waddr, m_waddr); end
        vectors++; if (rf_wdata !== m_wdata) begin miscompares++; $display("[TB] FAIL rnd_wdata c%0d got %h want %h", c, rf_wdata, m_wdata); end
      end
      if (ge) e_pend = 0;
      if (gl) l_pend = 0;
      if (!e_pend && $urandom_range(0, 1) == 1) begin e_pend = 1; exu_rd = pick_rd(); exu_data = $urandom; end
      if (!l_pend && $urandom_range(0, 1) == 1) begin l_pend = 1; lsu_rd = pick_rd(); lsu_data = $urandom; end
      exu_valid = e_pend;
      lsu_valid = l_pend;
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 7));
      iss_rd  = 5'($urandom_range(0, 7));
      #1;
      ge = f_grant_exu();
      gl = f_grant_lsu();
      vectors++; if (exu_ready !== ge) begin miscompares++; $display("[TB] FAIL rnd_exu_ready c%0d got %b want %b", c, exu_ready, ge); end
      vectors++; if (lsu_ready !== gl) begin miscompares++; $display("[TB] FAIL rnd_lsu_ready c%0d got %b want %b", c, lsu_ready, gl); end
      vectors++; if (iss_ready !== f_iss_ready()) begin miscompares++; $display("[TB] FAIL rnd_iss_ready c%0d got %b want %b", c, iss_ready, f_iss_ready()); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_issue_writeback();
    test_back_to_back();
    test_rd_zero();
    test_wb_error();
    test_reset_in_grant();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
